// File: rtl/div_n8_cc4.sv
// Radix-4 restoring divider: 16-bit dividend / 8-bit divisor.
// It produces two quotient bits per clock over four iterations, MSB digit first.
module div_n8_cc4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic        busy,
    output logic        done,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        ovf,
    output logic        dbz,
    output logic [1:0]  q_dig,
    output logic        q_dig_valid
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  d1_q, d1_d;
    logic [8:0]  d2_q, d2_d;
    logic [9:0]  d3_q, d3_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  rem_q, rem_d;
    logic [5:0]  qi_q, qi_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        ovf_q, ovf_d;
    logic        dbz_q, dbz_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [1:0]  q_dig_q, q_dig_d;
    logic        q_dig_valid_q, q_dig_valid_d;

    logic [9:0]  t_s;
    logic [10:0] diff1_s, diff2_s, diff3_s;
    logic [8:0]  ovf_diff_s;
    logic [1:0]  g_s;
    logic [10:0] rem_sel_s;

    // Digit selection: trial-subtract D, 2D and 3D; a clear borrow means g*D fits.
    always_comb begin
        t_s        = {rem_q, s_q[7:6]};
        diff1_s    = {1'b0, t_s} - {3'b000, d1_q};
        diff2_s    = {1'b0, t_s} - {2'b00, d2_q};
        diff3_s    = {1'b0, t_s} - {1'b0, d3_q};
        ovf_diff_s = {1'b0, a[15:8]} - {1'b0, d};
        if (!diff3_s[10]) begin
            g_s       = 2'b11;
            rem_sel_s = diff3_s;
        end else if (!diff2_s[10]) begin
            g_s       = 2'b10;
            rem_sel_s = diff2_s;
        end else if (!diff1_s[10]) begin
            g_s       = 2'b01;
            rem_sel_s = diff1_s;
        end else begin
            g_s       = 2'b00;
            rem_sel_s = {1'b0, t_s};
        end
    end

    // Next-state and output computation for the IDLE/RUN sequencer.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        d1_d          = d1_q;
        d2_d          = d2_q;
        d3_d          = d3_q;
        s_d           = s_q;
        rem_d         = rem_q;
        qi_d          = qi_q;
        q_d           = q_q;
        r_d           = r_q;
        ovf_d         = ovf_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        q_dig_d       = q_dig_q;
        q_dig_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = 2'd0;
                    d1_d    = d;
                    d2_d    = {d, 1'b0};
                    d3_d    = {1'b0, d, 1'b0} + {2'b00, d};
                    s_d     = a[7:0];
                    rem_d   = a[15:8];
                    qi_d    = 6'd0;
                    ovf_d   = ((ovf_diff_s >> 8) == 9'd0);
                    dbz_d   = (d == 8'd0);
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                // Overflow forces an all-ones digit stream; the datapath result is discarded.
                q_dig_d       = ovf_q ? 2'b11 : g_s;
                q_dig_valid_d = 1'b1;
                rem_d         = 8'(rem_sel_s);
                s_d           = {s_q[5:0], 2'b00};
                qi_d          = {qi_q[3:0], g_s};
                k_d           = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = ovf_q ? 8'hFF : {qi_q, g_s};
                    r_d     = ovf_q ? 8'h00 : 8'(rem_sel_s);
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= 2'd0;
            d1_q          <= 8'd0;
            d2_q          <= 9'd0;
            d3_q          <= 10'd0;
            s_q           <= 8'd0;
            rem_q         <= 8'd0;
            qi_q          <= 6'd0;
            q_q           <= 8'd0;
            r_q           <= 8'd0;
            ovf_q         <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            q_dig_q       <= 2'd0;
            q_dig_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            d1_q          <= d1_d;
            d2_q          <= d2_d;
            d3_q          <= d3_d;
            s_q           <= s_d;
            rem_q         <= rem_d;
            qi_q          <= qi_d;
            q_q           <= q_d;
            r_q           <= r_d;
            ovf_q         <= ovf_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            q_dig_q       <= q_dig_d;
            q_dig_valid_q <= q_dig_valid_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_q;
    assign r           = r_q;
    assign ovf         = ovf_q;
    assign dbz         = dbz_q;
    assign q_dig       = q_dig_q;
    assign q_dig_valid = q_dig_valid_q;

endmodule

// File: doc/div_n8_cc4.md
Name: div_n8_cc4

Overview:
Sequential radix-4 unsigned divider. It is the inverse of the team's 8-bit, 2-bit-digit-per-cycle serial multiplier.
- Divides a 16-bit dividend by an 8-bit divisor.
- Retires 2 quotient bits per clock over 4 iterations, MSB digit first.
- Outputs an 8-bit quotient, an 8-bit remainder and status flags.
- Sits beside the multiplier in the arithmetic netlist library, for garbled-circuit benches that need modular reduction of products.

Parameters:
N, 8, divisor/quotient/remainder width; dividend is 2N.
CC, 4, iteration count (N/2); fixed at 4 for this block.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
start  input  1  request; accepted only when busy=0.
a  input  16  dividend; sampled when start is accepted.
d  input  8  divisor; sampled when start is accepted.
busy  output  1  high during the 4 iteration cycles.
done  output  1  one-cycle pulse; q, r, ovf, dbz are valid.
q  output  8  quotient; held until the next accepted start.
r  output  8  remainder; held until the next accepted start.
ovf  output  1  a[15:8] >= d; quotient does not fit in 8 bits (includes d=0).
dbz  output  1  d == 0.
q_dig  output  2  current quotient digit (streaming, MSB digit first).
q_dig_valid  output  1  q_dig is valid this cycle.

Behaviour:
Reset and global rules:
- Reset is synchronous active-high, one clock, rst=1. All outputs go to 0 and state goes to IDLE.
- Reset mid-operation aborts immediately. No done pulse follows.

States: IDLE, RUN.
- IDLE: if start=1 at an edge, latch D=d, dividend shift register S=a[7:0], partial remainder R=a[15:8], iteration count k=0. Go to RUN; busy=1 after that edge.
- IDLE at the same edge: compute ovf = (a[15:8] >= d) and dbz = (d == 0), and register both.
- RUN, each edge k=0..3:
  - Form T = {R, S[7:6]} (10 bits).
  - Compare T against D, 2D and 3D (10-bit unsigned).
  - Digit g = largest value in 0..3 with g*D <= T.
  - R <= T - g*D (fits 8 bits because R < D is invariant).
  - S <= S << 2; q <= {q[5:0], g}.
  - q_dig <= g; q_dig_valid <= 1.
- At the edge where k=3: go to IDLE, busy<=0, done<=1.

Latency and handshake:
- Start accepted at edge E0. Digits are registered at edges E1..E4. done=1 in the cycle after E4, i.e. 4 cycles after acceptance.
- The final q_dig_valid coincides with done.
- done and q_dig_valid are single-cycle pulses; otherwise 0.
- start while busy=1 is ignored; inputs are not re-sampled.
- start in the cycle done=1 is accepted (state is IDLE), which gives back-to-back operation with no gap.

Overflow and divide-by-zero:
- Iterations still run for fixed 4-cycle latency, but are don't-care internally.
- At done with ovf=1: q=8'hFF, r=8'h00. q_dig still pulses 4 times, with value 2'b11.
- With dbz=1, ovf=1 also holds.

Output hold rules:
- q and r are updated only at completion. During RUN they hold the previous result; the internal quotient register is separate.
- ovf and dbz update at acceptance. They are valid from then until the next acceptance.

Arithmetic and timing structure:
- Unsigned only.
- Result invariant when ovf=0: a == q*d + r and r < d.
- Comparators use a subtract-and-borrow structure. No multipliers; 2D and 3D are formed by shift and add, computed once at load and registered.

Test Plan:
1. a=16'h1234, d=8'h56, start one cycle -> q_dig stream 00,11,01,10. Then done with q=8'h36, r=8'h10, ovf=0, dbz=0, exactly 4 cycles after acceptance.
2. a=16'hFEFF, d=8'hFF (max legal) -> q=8'hFF, r=8'hFE, ovf=0. Then a=16'h0500, d=8'h05 -> ovf=1, q=8'hFF, r=8'h00, dbz=0.
3. a=16'h1234, d=8'h00 -> dbz=1, ovf=1, q=8'hFF, r=8'h00. done still arrives 4 cycles after acceptance.
4. Start a=16'h0064, d=8'h07. Pulse start again with a=16'h0001, d=8'h01 two cycles later -> second start is ignored. Result q=8'h0E, r=8'h02.
5. Back-to-back: assert start in the done cycle with a=16'h00FF, d=8'h10 -> accepted. Next done 4 cycles later with q=8'h0F, r=8'h0F.
6. rst=1 during RUN, 2 cycles after acceptance -> next cycle all outputs 0, busy=0, no done pulse. A new start then completes normally (a=16'h0009, d=8'h03 -> q=8'h03, r=8'h00).
